// File: rtl/tm1638_key_reader_if.sv
// Pin-side bundle of the TM1638 key reader: arbiter handshake plus the shared STB/CLK/DIO pins.
// The reader owns the master modport; the pin arbiter / pad logic uses the slave side.
interface tm1638_key_reader_if;
  logic o_Bus_Req;
  logic i_Bus_Grant;
  logic o_SPI_Stb;
  logic o_SPI_Clk;
  logic o_SPI_Dio_Out;
  logic o_SPI_Dio_Oe;
  logic i_SPI_Dio;

  modport master (
    output o_Bus_Req,
    output o_SPI_Stb,
    output o_SPI_Clk,
    output o_SPI_Dio_Out,
    output o_SPI_Dio_Oe,
    input  i_Bus_Grant,
    input  i_SPI_Dio
  );

  modport slave (
    input  o_Bus_Req,
    input  o_SPI_Stb,
    input  o_SPI_Clk,
    input  o_SPI_Dio_Out,
    input  o_SPI_Dio_Oe,
    output i_Bus_Grant,
    output i_SPI_Dio
  );
endinterface

// File: rtl/tm1638_key_reader.sv
// Periodic TM1638 key scan: sends the 0x42 read command, turns DIO around, shifts in
// four key bytes and publishes the eight front-panel buttons.
module tm1638_key_reader #(
  parameter int SPI_CYCLES        = 200,
  parameter int SCAN_CYCLES       = 27_000,
  parameter int TURNAROUND_CYCLES = 54
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  tm1638_key_reader_if.master  bus,
  output logic [7:0]           o_Keys,
  output logic                 o_Keys_Valid,
  output logic                 o_Keys_Changed,
  output logic                 o_Busy
);

  localparam int MAX_AB  = (SCAN_CYCLES > SPI_CYCLES) ? SCAN_CYCLES : SPI_CYCLES;
  localparam int MAX_CNT = (MAX_AB > TURNAROUND_CYCLES) ? MAX_AB : TURNAROUND_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SPI_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURNAROUND_CYCLES - 1);
  localparam logic [7:0]       CMD_BYTE  = 8'h42;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CMD,
    S_WAIT,
    S_READ,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       half_q, half_d;
  logic [31:0]      shreg_q, shreg_d;
  logic             clk_q, clk_d;
  logic             stb_q, stb_d;
  logic             dout_q, dout_d;
  logic             oe_q, oe_d;
  logic             req_q, req_d;
  logic [7:0]       keys_q, keys_d;
  logic             valid_q, valid_d;
  logic             changed_q, changed_d;
  logic [7:0]       keys_new;
  logic             half_end;

  // Only bit 0 and bit 4 of each received byte carry a front-panel button.
  always_comb begin
    keys_new = '0;
    for (int i = 0; i < 4; i++) begin
      keys_new[i]     = shreg_q[8*i];
      keys_new[i + 4] = shreg_q[8*i + 4];
    end
  end

  assign half_end = (cnt_q == HALF_LAST);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      half_q    <= '0;
      shreg_q   <= '0;
      clk_q     <= 1'b1;
      stb_q     <= 1'b1;
      dout_q    <= 1'b1;
      oe_q      <= 1'b0;
      req_q     <= 1'b0;
      keys_q    <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      shreg_q   <= shreg_d;
      clk_q     <= clk_d;
      stb_q     <= stb_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      req_q     <= req_d;
      keys_q    <= keys_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    shreg_d   = shreg_q;
    clk_d     = clk_q;
    stb_d     = stb_q;
    dout_d    = dout_q;
    oe_d      = oe_q;
    req_d     = req_q;
    keys_d    = keys_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cnt_q == SCAN_LAST) begin
          state_d = S_REQ;
          cnt_d   = '0;
          req_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_REQ: begin
        if (bus.i_Bus_Grant) begin
          state_d = S_CMD;
          stb_d   = 1'b0;
          oe_d    = 1'b1;
          cnt_d   = '0;
          half_d  = '0;
        end
      end

      // Half 0 is the lead-in high after STB falls; odd halves are CLK low.
      S_CMD: begin
        if (half_end) begin
          cnt_d  = '0;
          half_d = half_q + 6'd1;
          if (half_q == 6'd16) begin
            state_d = S_WAIT;
            oe_d    = 1'b0;
            dout_d  = 1'b1;
          end else if (!half_q[0]) begin
            clk_d  = 1'b0;
            dout_d = CMD_BYTE[half_q[3:1]];
          end else begin
            clk_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT: begin
        if (cnt_q == TURN_LAST) begin
          state_d = S_READ;
          cnt_d   = '0;
          half_d  = '0;
          clk_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Even halves are CLK low; DIO is captured on the rising transition, LSB first.
      S_READ: begin
        if (half_end) begin
          cnt_d  = '0;
          half_d = half_q + 6'd1;
          if (!half_q[0]) begin
            clk_d   = 1'b1;
            shreg_d = {bus.i_SPI_Dio, shreg_q[31:1]};
          end else if (half_q == 6'd63) begin
            state_d = S_DONE;
          end else begin
            clk_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        if (half_end) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          stb_d     = 1'b1;
          req_d     = 1'b0;
          keys_d    = keys_new;
          valid_d   = 1'b1;
          changed_d = (keys_new != keys_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_Bus_Req     = req_q;
  assign bus.o_SPI_Stb     = stb_q;
  assign bus.o_SPI_Clk     = clk_q;
  assign bus.o_SPI_Dio_Out = dout_q;
  assign bus.o_SPI_Dio_Oe  = oe_q;
  assign o_Keys            = keys_q;
  assign o_Keys_Valid      = valid_q;
  assign o_Keys_Changed    = changed_q;
  assign o_Busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Randomized bench for tm1638_key_reader: a TM1638 responder feeds key bytes and a
// byte-level reference model predicts keys, change flags and pin timing.
module tb_tm1638_key_reader;

  localparam int SPI_C  = 1;
  localparam int SCAN_C = 10;
  localparam int TURN_C = 2;
  localparam int STB_LOW = 82 * SPI_C + TURN_C;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b0;
  logic [7:0] o_Keys;
  logic       o_Keys_Valid;
  logic       o_Keys_Changed;
  logic       o_Busy;

  tm1638_key_reader_if bus ();

  tm1638_key_reader #(
    .SPI_CYCLES        (SPI_C),
    .SCAN_CYCLES       (SCAN_C),
    .TURNAROUND_CYCLES (TURN_C)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Rst          (i_Rst),
    .bus            (bus),
    .o_Keys         (o_Keys),
    .o_Keys_Valid   (o_Keys_Valid),
    .o_Keys_Changed (o_Keys_Changed),
    .o_Busy         (o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_valid = 0;
  bit          clk_bad = 0;
  logic [7:0]  model_keys = 8'h00;
  logic [31:0] resp_word = 32'h0;
  logic        resp_dio = 1'b1;
  int          read_idx = 0;

  assign bus.i_SPI_Dio = resp_dio;

  // TM1638 responder: a new key bit appears on every CLK fall once DIO is released.
  always @(negedge bus.o_SPI_Clk) begin
    if (bus.o_SPI_Dio_Oe) begin
      read_idx = 0;
    end else if (!bus.o_SPI_Stb && read_idx < 32) begin
      resp_dio = resp_word[read_idx];
      read_idx = read_idx + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_Clk);
    cyc++;
    if (bus.o_SPI_Stb === 1'b1 && bus.o_SPI_Clk !== 1'b1) clk_bad = 1;
  endtask

  function automatic logic [7:0] expectKeys(input logic [31:0] word);
    logic [7:0] bytes [4];
    logic [7:0] k;
    for (int i = 0; i < 4; i++) bytes[i] = word[8*i +: 8];
    k = '0;
    for (int i = 0; i < 4; i++) begin
      k[i]     = bytes[i][0];
      k[i + 4] = bytes[i][4];
    end
    return k;
  endfunction

  // One complete scan: idle interval, optional grant stall, command, turnaround, read.
  task automatic applyStimulus(input logic [31:0] word, input int grant_delay, input string tag);
    int         req_s = 0, stb_s = 0, stb_low = 0, oe_gap = 0, cmd_idx = 0;
    bit         req_seen = 0, stb_seen = 0, read_seen = 0, done = 0;
    bit         idle_bad = 0, hold_bad = 0, oe_in_read = 0;
    logic [7:0] cmd_bits = '0;
    logic [7:0] got_keys = '0, exp_keys;
    logic       got_changed = 1'b0, prev_clk = 1'b1;

    resp_word       = word;
    bus.i_Bus_Grant = (grant_delay == 0);
    for (int n = 0; n < SCAN_C + grant_delay + 300 && !done; n++) begin
      tick();
      if (!req_seen) begin
        if (bus.o_Bus_Req) begin
          req_seen = 1;
          req_s    = cyc;
        end else if (bus.o_SPI_Stb !== 1'b1 || bus.o_SPI_Clk !== 1'b1 || bus.o_SPI_Dio_Oe !== 1'b0 ||
                     o_Busy !== 1'b0 || o_Keys_Valid !== 1'b0) begin
          idle_bad = 1;
        end
      end
      if (req_seen && !stb_seen) begin
        if (!bus.o_SPI_Stb) begin
          stb_seen = 1;
          stb_s    = cyc;
        end else begin
          if (bus.o_SPI_Clk !== 1'b1 || o_Busy !== 1'b1 || bus.o_Bus_Req !== 1'b1) hold_bad = 1;
          if (cyc - req_s == grant_delay) bus.i_Bus_Grant = 1'b1;
        end
      end
      if (stb_seen) begin
        if (!bus.o_SPI_Stb) stb_low++;
        if (bus.o_SPI_Clk && !prev_clk && bus.o_SPI_Dio_Oe && cmd_idx < 8) begin
          cmd_bits[cmd_idx] = bus.o_SPI_Dio_Out;
          cmd_idx++;
        end
        if (!read_seen) begin
          if (cmd_idx == 8 && !bus.o_SPI_Dio_Oe && bus.o_SPI_Clk) oe_gap++;
          else if (!bus.o_SPI_Dio_Oe && !bus.o_SPI_Clk) read_seen = 1;
        end else if (bus.o_SPI_Dio_Oe) begin
          oe_in_read = 1;
        end
        if (o_Keys_Valid) begin
          done        = 1;
          got_keys    = o_Keys;
          got_changed = o_Keys_Changed;
        end
      end
      prev_clk = bus.o_SPI_Clk;
    end

    if (!done) begin
      checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end

    exp_keys = expectKeys(word);
    checkOutput({tag, "_idle_len"}, req_s - last_valid, SCAN_C);
    checkOutput({tag, "_idle_quiet"}, idle_bad, 0);
    checkOutput({tag, "_grant_lat"}, stb_s - req_s, grant_delay + 1);
    checkOutput({tag, "_grant_hold"}, hold_bad, 0);
    checkOutput({tag, "_cmd"}, cmd_bits, 8'h42);
    checkOutput({tag, "_turnaround"}, (oe_gap >= TURN_C), 1);
    checkOutput({tag, "_oe_in_read"}, oe_in_read, 0);
    checkOutput({tag, "_stb_low"}, stb_low, STB_LOW);
    checkOutput({tag, "_keys"}, got_keys, exp_keys);
    checkOutput({tag, "_changed"}, got_changed, (exp_keys != model_keys));
    model_keys = exp_keys;
    last_valid = cyc;

    tick();
    checkOutput({tag, "_pulse_width"}, {o_Keys_Valid, o_Keys_Changed}, 2'b00);
  endtask

  initial begin
    bit found;
    bus.i_Bus_Grant = 1'b1;
    i_Rst = 1'b0;
    repeat (3) tick();
    checkOutput("reset_outs",
      {bus.o_SPI_Stb, bus.o_SPI_Clk, bus.o_SPI_Dio_Out, bus.o_SPI_Dio_Oe, bus.o_Bus_Req,
       o_Keys_Valid, o_Keys_Changed, o_Busy, o_Keys}, 16'hE000);
    i_Rst      = 1'b1;
    last_valid = cyc;

    applyStimulus({8'h00, 8'h11, 8'h10, 8'h01}, 0, "decode");
    applyStimulus({8'h00, 8'h11, 8'h10, 8'h01}, 0, "nochange");
    applyStimulus($urandom, 50, "grantwait");
    for (int i = 0; i < 6; i++) begin
      applyStimulus($urandom, int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end
    applyStimulus(32'h1111_1111, 0, "allkeys");

    // Abort a scan partway through the read phase.
    resp_word = $urandom;
    found     = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      tick();
      if (!bus.o_SPI_Stb && !bus.o_SPI_Dio_Oe && read_idx >= 10 && read_idx < 32) found = 1;
    end
    checkOutput("midread_reach", found, 1);
    i_Rst = 1'b0;
    tick();
    checkOutput("midread_reset",
      {bus.o_SPI_Stb, bus.o_SPI_Clk, bus.o_SPI_Dio_Out, bus.o_SPI_Dio_Oe, bus.o_Bus_Req,
       o_Keys_Valid, o_Keys_Changed, o_Busy, o_Keys}, 16'hE000);
    repeat (2) tick();
    i_Rst      = 1'b1;
    last_valid = cyc;
    model_keys = 8'h00;

    applyStimulus($urandom, 0, "after_reset");
    applyStimulus($urandom, 2, "after_reset2");

    checkOutput("clk_while_stb_high", clk_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
